// File: rtl/osd_perm_sched_if.sv
// Job/result handshake bundle for the OSD column-permutation sequencer,
// including the side channel to the external combinational column permuter.
interface osd_perm_sched_if #(
  parameter int N     = 8,
  parameter int K     = 4,
  parameter int IDX_W = $clog2(N),
  parameter int REL_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N*REL_W-1:0]   rel_flat;
  logic [K*N-1:0]       g_flat;
  logic [N*IDX_W-1:0]   perm_lambda;
  logic [K*N-1:0]       perm_g;
  logic [K*N-1:0]       perm_gp;
  logic                 out_valid;
  logic                 out_ready;
  logic [K*N-1:0]       gp_flat;
  logic [N*IDX_W-1:0]   lambda_out;

  // Sequencer side: receives jobs, drives the permuter, presents results.
  modport slave (
    input  in_valid, rel_flat, g_flat, perm_gp, out_ready,
    output in_ready, perm_lambda, perm_g, out_valid, gp_flat, lambda_out
  );

  // Environment side: job source, permuter and result sink.
  modport master (
    output in_valid, rel_flat, g_flat, perm_gp, out_ready,
    input  in_ready, perm_lambda, perm_g, out_valid, gp_flat, lambda_out
  );
endinterface

// File: rtl/osd_perm_sched.sv
// OSD permutation sequencer: odd-even transposition sort of reliabilities
// (one pass per cycle) to build lambda1, then capture of the permuted G.
module osd_perm_sched #(
  parameter int N     = 8,
  parameter int K     = 4,
  parameter int IDX_W = $clog2(N),
  parameter int REL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  osd_perm_sched_if.slave    bus,
  output logic               busy
);
  localparam int PASS_W = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_SORT, S_PERM, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_in_ready;
  logic                 w_out_valid;
  logic                 w_busy;

  logic [REL_W-1:0]     r_rel [N];
  logic [IDX_W-1:0]     r_idx [N];
  logic [REL_W-1:0]     w_rel_nx [N];
  logic [IDX_W-1:0]     w_idx_nx [N];
  logic [N-2:0]         w_act;
  logic [K*N-1:0]       r_g;
  logic [PASS_W-1:0]    r_pass;
  logic [K*N-1:0]       r_gp;
  logic [N*IDX_W-1:0]   r_lambda;
  logic [N*IDX_W-1:0]   w_lambda_flat;

  // A pair is active when its left index has the pass parity and the right
  // element ranks higher (larger magnitude, or equal with lower origin index).
  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_cmp
      assign w_act[gi] = (r_pass[0] == 1'(gi % 2)) &&
                         ((r_rel[gi] < r_rel[gi+1]) ||
                          ((r_rel[gi] == r_rel[gi+1]) && (r_idx[gi] > r_idx[gi+1])));
    end

    for (gi = 0; gi < N; gi++) begin : g_elem
      if (gi == 0) begin : g_first
        assign w_rel_nx[gi] = w_act[0] ? r_rel[1] : r_rel[0];
        assign w_idx_nx[gi] = w_act[0] ? r_idx[1] : r_idx[0];
      end else if (gi == N - 1) begin : g_last
        assign w_rel_nx[gi] = w_act[N-2] ? r_rel[N-2] : r_rel[N-1];
        assign w_idx_nx[gi] = w_act[N-2] ? r_idx[N-2] : r_idx[N-1];
      end else begin : g_mid
        assign w_rel_nx[gi] = w_act[gi]   ? r_rel[gi+1] :
                              w_act[gi-1] ? r_rel[gi-1] : r_rel[gi];
        assign w_idx_nx[gi] = w_act[gi]   ? r_idx[gi+1] :
                              w_act[gi-1] ? r_idx[gi-1] : r_idx[gi];
      end
      assign w_lambda_flat[gi*IDX_W +: IDX_W] = r_idx[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (bus.in_valid) w_state_next = S_SORT;
      end
      S_SORT: begin
        if (r_pass == PASS_W'(N - 1)) w_state_next = S_PERM;
      end
      S_PERM: begin
        w_state_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Index registers come out of reset as the identity so lambda is always a
  // valid permutation, even before the first job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        r_rel[c] <= '0;
        r_idx[c] <= IDX_W'(c);
      end
      r_g      <= '0;
      r_pass   <= '0;
      r_gp     <= '0;
      r_lambda <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            for (int c = 0; c < N; c++) begin
              r_rel[c] <= bus.rel_flat[c*REL_W +: REL_W];
              r_idx[c] <= IDX_W'(c);
            end
            r_g    <= bus.g_flat;
            r_pass <= '0;
          end
        end
        S_SORT: begin
          for (int c = 0; c < N; c++) begin
            r_rel[c] <= w_rel_nx[c];
            r_idx[c] <= w_idx_nx[c];
          end
          r_pass <= r_pass + PASS_W'(1);
        end
        S_PERM: begin
          r_gp     <= bus.perm_gp;
          r_lambda <= w_lambda_flat;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.perm_lambda = w_lambda_flat;
  assign bus.perm_g      = r_g;
  assign bus.gp_flat     = r_gp;
  assign bus.lambda_out  = r_lambda;
  assign busy            = w_busy;
endmodule

// File: tb/tb_osd_perm_sched.sv
// Directed bench for osd_perm_sched: hand-computed sort orders, permuted G,
// latency, backpressure, ignored input while busy, and mid-sort reset.
module tb_osd_perm_sched;
  localparam int N     = 8;
  localparam int K     = 4;
  localparam int IDX_W = 3;
  localparam int REL_W = 8;

  logic clk;
  logic rst_n;
  logic busy;

  int n_vec;
  int n_err;

  osd_perm_sched_if #(.N(N), .K(K), .IDX_W(IDX_W), .REL_W(REL_W)) bus ();

  osd_perm_sched #(.N(N), .K(K), .IDX_W(IDX_W), .REL_W(REL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational column permuter: Gp[r][c] = G[r][lambda[c]].
  always_comb begin
    bus.perm_gp = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < N; c++)
        bus.perm_gp[r*N + c] = bus.perm_g[r*N + int'(bus.perm_lambda[c*IDX_W +: IDX_W])];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  function automatic logic [N*REL_W-1:0] pack_rel(input logic [7:0] rel[N]);
    logic [N*REL_W-1:0] v;
    for (int c = 0; c < N; c++) v[c*REL_W +: REL_W] = rel[c];
    return v;
  endfunction

  function automatic logic [N*IDX_W-1:0] pack_lam(input int lam[N]);
    logic [N*IDX_W-1:0] v;
    for (int c = 0; c < N; c++) v[c*IDX_W +: IDX_W] = IDX_W'(lam[c]);
    return v;
  endfunction

  // Offer a job, count edges to out_valid, then check the held result.
  task automatic start_job(input string tag, input logic [7:0] rel[N],
                           input logic [K*N-1:0] g, input int lam[N],
                           input logic [K*N-1:0] gp_exp);
    int cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 40) check({tag, "_rdy_timeout"}, 64'(bus.in_ready), 64'd1);
    bus.rel_flat = pack_rel(rel);
    bus.g_flat   = g;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_in_ready_low"}, 64'(bus.in_ready), 64'd0);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd9);
    check({tag, "_lambda"}, 64'(bus.lambda_out), 64'(pack_lam(lam)));
    check({tag, "_gp"}, 64'(bus.gp_flat), 64'(gp_exp));
  endtask

  task automatic finish_job(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_ovalid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_in_ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  logic [7:0]     rel_a [N];
  logic [7:0]     rel_b [N];
  int             lam_a [N];
  int             lam_b [N];
  logic [K*N-1:0] held_gp;
  logic [N*IDX_W-1:0] held_lam;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.rel_flat  = '0;
    bus.g_flat    = '0;
    #23;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gp", 64'(bus.gp_flat), 64'd0);
    check("rst_lambda", 64'(bus.lambda_out), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mixed magnitudes with ties: 70(5) 60(7) 50(1) 50(3) 30(2) 20(6) 10(0) 0(4)
    rel_a = '{8'd10, 8'd50, 8'd30, 8'd50, 8'd0, 8'd70, 8'd20, 8'd60};
    lam_a = '{5, 7, 1, 3, 2, 6, 0, 4};
    start_job("mixed", rel_a, 32'h0000_0002, lam_a, 32'h0000_0004);
    finish_job("mixed");

    rel_b = '{8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    lam_b = '{0, 1, 2, 3, 4, 5, 6, 7};
    start_job("desc", rel_b, 32'hA5C3_1E7B, lam_b, 32'hA5C3_1E7B);
    finish_job("desc");

    rel_b = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    lam_b = '{7, 6, 5, 4, 3, 2, 1, 0};
    start_job("asc", rel_b, 32'h0000_0001, lam_b, 32'h0000_0080);
    finish_job("asc");

    rel_b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    lam_b = '{0, 1, 2, 3, 4, 5, 6, 7};
    start_job("ties_ff", rel_b, 32'h1234_5678, lam_b, 32'h1234_5678);
    finish_job("ties_ff");

    // Backpressure in DONE with a stray job offered meanwhile.
    bus.out_ready = 1'b0;
    rel_b = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    lam_b = '{7, 6, 5, 4, 3, 2, 1, 0};
    start_job("bp", rel_b, 32'h0000_0001, lam_b, 32'h0000_0080);
    held_gp  = 32'h0000_0080;
    held_lam = pack_lam(lam_b);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.rel_flat = pack_rel(rel_a);
        bus.g_flat   = 32'hFFFF_FFFF;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_ovalid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp_hold%0d_gp", i), 64'(bus.gp_flat), 64'(held_gp));
      check($sformatf("bp_hold%0d_lambda", i), 64'(bus.lambda_out), 64'(held_lam));
      check($sformatf("bp_hold%0d_in_ready", i), 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    check("bp_perm_g_kept", 64'(bus.perm_g), 64'h0000_0001);
    finish_job("bp");
    start_job("after_bp", rel_a, 32'h0000_0002, lam_a, 32'h0000_0004);
    finish_job("after_bp");

    // Asynchronous reset landing between edges while pass 3 is pending.
    bus.rel_flat = pack_rel(rel_a);
    bus.g_flat   = 32'h0000_0002;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_lambda", 64'(bus.lambda_out), 64'd0);
    check("mid_rst_gp", 64'(bus.gp_flat), 64'd0);
    check("mid_rst_perm_g", 64'(bus.perm_g), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid_hold", 64'(bus.out_valid), 64'd0);
    rel_b = '{8'd3, 8'd200, 8'd200, 8'd9, 8'd128, 8'd127, 8'd1, 8'd255};
    lam_b = '{7, 1, 2, 4, 5, 3, 0, 6};
    start_job("post_rst", rel_b, 32'h0000_0080, lam_b, 32'h0000_0001);
    finish_job("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
